pipe_stage_elastic: RTL

- Parametrised successor to the fixed inter-stage pipeline registers.
- Carries a generic payload through one ready/valid elastic stage with a 2-entry skid buffer, flush and bubble insertion.
- Control field is forced to zero whenever no valid instruction is presented, so writes are killed on bubbles.
- Instantiated between any two core stages (F/D, D/E, E/M, M/W) in place of the hand-written per-stage registers.

---
 rtl/pipe_stage_elastic.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic ready/valid pipeline stage with 2-entry skid buffer, flush and bubble masking.
// Optional perf counters (stall_cnt, bubble_cnt) enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_elastic #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_WIDTH = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e state;
    state_e state_nx;

    logic in_ready_q;
    logic out_valid_q;
    logic in_fire;
    logic out_fire;

    logic or_load_in;
    logic or_load_sr;
    logic sr_load_in;
    logic clr_ctrl;

    logic [CTRL_WIDTH-1:0] or_ctrl;
    logic [DATA_WIDTH-1:0] or_data;
    logic [CTRL_WIDTH-1:0] sr_ctrl;
    logic [DATA_WIDTH-1:0] sr_data;

    // Handshake flags are kept as flops so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_nx;
            in_ready_q  <= (state_nx != TWO);
            out_valid_q <= (state_nx != EMPTY);
        end
    end

    always_comb begin
        state_nx   = state;
        or_load_in = 1'b0;
        or_load_sr = 1'b0;
        sr_load_in = 1'b0;
        clr_ctrl   = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
            clr_ctrl = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nx   = ONE;
                        or_load_in = 1'b1;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        (in_fire && out_fire): begin
                            or_load_in = 1'b1;
                        end
                        (in_fire && !out_fire): begin
                            state_nx   = TWO;
                            sr_load_in = 1'b1;
                        end
                        (!in_fire && out_fire): begin
                            state_nx = EMPTY;
                        end
                        default: begin
                            state_nx = ONE;
                        end
                    endcase
                end
                TWO: begin
                    if (out_fire) begin
                        state_nx   = ONE;
                        or_load_sr = 1'b1;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        in_fire   = in_valid & in_ready_q;
        out_fire  = out_valid_q & out_ready;
        out_ctrl  = or_ctrl & {CTRL_WIDTH{out_valid_q}};
        out_data  = or_data;
    end

    // Flush clears only the control fields; data is left as-is for the held output value.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_ctrl <= '0;
            or_data <= RESET_DATA;
            sr_ctrl <= '0;
            sr_data <= RESET_DATA;
        end else begin
            if (clr_ctrl) begin
                or_ctrl <= '0;
                sr_ctrl <= '0;
            end
            if (or_load_in) begin
                or_ctrl <= in_ctrl;
                or_data <= in_data;
            end else if (or_load_sr) begin
                or_ctrl <= sr_ctrl;
                or_data <= sr_data;
            end
            if (sr_load_in) begin
                sr_ctrl <= in_ctrl;
                sr_data <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (!out_valid_q && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule
